// File: rtl/pipe_hazard_irq_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IRQ_PEND = 2'd1,
    TRAP     = 2'd2
  } irq_state_e;

  // addi x0, x0, 0 -- what a flushed IF/ID slot decodes as
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_irq_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush/redirect/trap outputs.
// Latency: n/a (wires only).
// Backpressure: lsu_busy from MEM is the only hold source carried here.
// Ports: master = pipeline/CSR side, slave = sequencer side.
interface pipe_hazard_irq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_lsu_busy;
  logic [4:0]      i_id_rs1;
  logic [4:0]      i_id_rs2;
  logic            i_id_use_rs1;
  logic            i_id_use_rs2;
  logic [4:0]      i_ex_rd;
  logic            i_ex_rd_wren;
  logic            i_ex_is_load;
  logic            i_ex_insn_vld;
  logic [XLEN-1:0] i_ex_pc;
  logic            i_ex_mispredict;
  logic [XLEN-1:0] i_ex_br_target;
  logic            i_ex_is_mret;
  logic            i_irq_req;
  logic [XLEN-1:0] i_mtvec;
  logic [XLEN-1:0] i_mepc;

  logic            o_pc_stall;
  logic            o_ifid_stall;
  logic            o_ifid_flush;
  logic            o_idex_stall;
  logic            o_idex_flush;
  logic            o_exmem_stall;
  logic            o_exmem_flush;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_trap_take;
  logic [XLEN-1:0] o_trap_epc;
  logic [1:0]      o_irq_state;

  modport master (
    output i_lsu_busy, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_insn_vld, i_ex_pc,
           i_ex_mispredict, i_ex_br_target, i_ex_is_mret, i_irq_req,
           i_mtvec, i_mepc,
    input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall,
           o_idex_flush, o_exmem_stall, o_exmem_flush, o_redirect,
           o_redirect_pc, o_trap_take, o_trap_epc, o_irq_state
  );

  modport slave (
    input  i_lsu_busy, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_ex_rd, i_ex_rd_wren, i_ex_is_load, i_ex_insn_vld, i_ex_pc,
           i_ex_mispredict, i_ex_br_target, i_ex_is_mret, i_irq_req,
           i_mtvec, i_mepc,
    output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall,
           o_idex_flush, o_exmem_stall, o_exmem_flush, o_redirect,
           o_redirect_pc, o_trap_take, o_trap_epc, o_irq_state
  );
endinterface

// File: rtl/pipe_hazard_irq_ctrl_hazard_detect.sv
// Load-use comparator: EX load whose rd feeds a source operand of the ID insn.
// Latency: combinational.
// Backpressure: none; result is qualified by the sequencer's priority chain.
// Ports: ID rs1/rs2 + use flags, EX rd/wren/is_load in; load_use out.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_rd_wren,
  input  logic       ex_is_load,
  output logic       load_use
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is never a real dependency
  assign load_use = ex_is_load && ex_rd_wren && (ex_rd != REG_ZERO) &&
                    (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_hazard_irq_ctrl.sv
// Pipeline stall/flush/redirect sequencer with interrupt entry and mret return.
// Latency: controls are combinational from inputs; FSM/refill counter 1 cycle.
// Backpressure: lsu_busy holds all four stages and freezes the FSM and counter.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave side of the ctrl if).
module pipe_hazard_irq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REFILL_CYCLES = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  pipe_hazard_irq_ctrl_if.slave  bus
);
  localparam int             CW        = (REFILL_CYCLES > 0) ? $clog2(REFILL_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  REFILL_LD = CW'(REFILL_CYCLES);

  irq_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic load_use;
  logic busy;
  logic mret_fire;
  logic redir_evt;
  logic capture;

  hazard_detect u_hazard_detect (
    .id_rs1     (bus.i_id_rs1),
    .id_rs2     (bus.i_id_rs2),
    .id_use_rs1 (bus.i_id_use_rs1),
    .id_use_rs2 (bus.i_id_use_rs2),
    .ex_rd      (bus.i_ex_rd),
    .ex_rd_wren (bus.i_ex_rd_wren),
    .ex_is_load (bus.i_ex_is_load),
    .load_use   (load_use)
  );

  assign busy      = bus.i_lsu_busy;
  assign mret_fire = bus.i_ex_insn_vld && bus.i_ex_is_mret;
  assign redir_evt = mret_fire || bus.i_ex_mispredict;
  // The EX instruction becomes the interrupted one; a redirecting EX insn
  // is never chosen because its successor PC is not yet architectural.
  assign capture   = (state_q == IRQ_PEND) && bus.i_irq_req &&
                     bus.i_ex_insn_vld && !redir_evt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    if (!busy) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (state_q != TRAP && mret_fire) cnt_d = REFILL_LD;
      case (state_q)
        RUN: begin
          if (!redir_evt && bus.i_irq_req && cnt_q == '0) state_d = IRQ_PEND;
        end
        IRQ_PEND: begin
          if (!redir_evt) begin
            if (!bus.i_irq_req) begin
              state_d = RUN;
            end else if (capture) begin
              state_d = TRAP;
              epc_d   = bus.i_ex_pc;
            end
          end
        end
        TRAP: begin
          state_d = RUN;
          cnt_d   = REFILL_LD;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.o_pc_stall    = 1'b0;
    bus.o_ifid_stall  = 1'b0;
    bus.o_ifid_flush  = 1'b0;
    bus.o_idex_stall  = 1'b0;
    bus.o_idex_flush  = 1'b0;
    bus.o_exmem_stall = 1'b0;
    bus.o_exmem_flush = 1'b0;
    bus.o_redirect    = 1'b0;
    bus.o_redirect_pc = '0;
    bus.o_trap_take   = 1'b0;
    bus.o_trap_epc    = '0;
    bus.o_irq_state   = 2'(RUN);
    if (i_rst_n) begin
      bus.o_irq_state = 2'(state_q);
      if (busy) begin
        bus.o_pc_stall    = 1'b1;
        bus.o_ifid_stall  = 1'b1;
        bus.o_idex_stall  = 1'b1;
        bus.o_exmem_stall = 1'b1;
      end else if (state_q == TRAP) begin
        bus.o_ifid_flush  = 1'b1;
        bus.o_idex_flush  = 1'b1;
        bus.o_exmem_flush = 1'b1;
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = bus.i_mtvec;
        bus.o_trap_take   = 1'b1;
        bus.o_trap_epc    = epc_q;
      end else if (mret_fire) begin
        bus.o_ifid_flush  = 1'b1;
        bus.o_idex_flush  = 1'b1;
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = bus.i_mepc;
      end else if (bus.i_ex_mispredict) begin
        bus.o_ifid_flush  = 1'b1;
        bus.o_idex_flush  = 1'b1;
        bus.o_redirect    = 1'b1;
        bus.o_redirect_pc = bus.i_ex_br_target;
      end else if (capture) begin
        // Park the interrupted insn in ID/EX and keep it out of MEM; the
        // TRAP cycle then flushes it while older insns drain normally.
        bus.o_pc_stall    = 1'b1;
        bus.o_ifid_stall  = 1'b1;
        bus.o_idex_stall  = 1'b1;
        bus.o_exmem_flush = 1'b1;
      end else if (load_use) begin
        bus.o_pc_stall    = 1'b1;
        bus.o_ifid_stall  = 1'b1;
        bus.o_idex_flush  = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_irq_ctrl.sv
// Directed vectors for the hazard/irq sequencer: a table of single-cycle
// cases followed by hand-written interrupt, busy, mispredict and reset runs.
module tb_pipe_hazard_irq_ctrl;
  localparam int XLEN = 32;

  // flag order: pc_st ifid_st ifid_fl idex_st idex_fl exmem_st exmem_fl redir trap
  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_LU   = 9'b110010000;
  localparam logic [8:0] F_MP   = 9'b001010010;
  localparam logic [8:0] F_BUSY = 9'b110101000;
  localparam logic [8:0] F_CAP  = 9'b110100100;
  localparam logic [8:0] F_TRAP = 9'b001010111;

  typedef struct packed {
    logic            lsu_busy;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic [4:0]      ex_rd;
    logic            rd_wren;
    logic            is_load;
    logic            insn_vld;
    logic [XLEN-1:0] ex_pc;
    logic            misp;
    logic [XLEN-1:0] br_target;
    logic            is_mret;
    logic            irq_req;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
  } in_t;

  typedef struct packed {
    logic [8:0]      f;
    logic [XLEN-1:0] rpc;
    logic [XLEN-1:0] epc;
    logic [1:0]      st;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  pipe_hazard_irq_ctrl_if #(.XLEN(XLEN)) bus ();

  pipe_hazard_irq_ctrl #(.XLEN(XLEN), .REFILL_CYCLES(3)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  function automatic out_t mk(logic [8:0] f, logic [XLEN-1:0] rpc,
                              logic [XLEN-1:0] epc, logic [1:0] st);
    out_t o;
    o.f = f; o.rpc = rpc; o.epc = epc; o.st = st;
    return o;
  endfunction

  task automatic apply(input in_t v);
    bus.i_lsu_busy      = v.lsu_busy;
    bus.i_id_rs1        = v.id_rs1;
    bus.i_id_rs2        = v.id_rs2;
    bus.i_id_use_rs1    = v.use_rs1;
    bus.i_id_use_rs2    = v.use_rs2;
    bus.i_ex_rd         = v.ex_rd;
    bus.i_ex_rd_wren    = v.rd_wren;
    bus.i_ex_is_load    = v.is_load;
    bus.i_ex_insn_vld   = v.insn_vld;
    bus.i_ex_pc         = v.ex_pc;
    bus.i_ex_mispredict = v.misp;
    bus.i_ex_br_target  = v.br_target;
    bus.i_ex_is_mret    = v.is_mret;
    bus.i_irq_req       = v.irq_req;
    bus.i_mtvec         = v.mtvec;
    bus.i_mepc          = v.mepc;
    #1;
  endtask

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act.f   = {bus.o_pc_stall, bus.o_ifid_stall, bus.o_ifid_flush,
               bus.o_idex_stall, bus.o_idex_flush, bus.o_exmem_stall,
               bus.o_exmem_flush, bus.o_redirect, bus.o_trap_take};
    act.rpc = bus.o_redirect_pc;
    act.epc = bus.o_trap_epc;
    act.st  = bus.o_irq_state;
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got flags=%b rpc=%h epc=%h st=%0d, want flags=%b rpc=%h epc=%h st=%0d",
               name, act.f, act.rpc, act.epc, act.st, exp.f, exp.rpc, exp.epc, exp.st);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input in_t base, input int n);
    apply(base);
    for (int k = 0; k < n; k++) tick();
  endtask

  vec_t tbl[13];
  in_t  base, v;

  initial begin
    base       = '0;
    base.mtvec = 32'h0000_0100;

    v = base;                                                     tbl[0]  = '{v, mk(F_NONE, 0, 0, 0), "idle"};
    v = base; v.is_load = 1; v.rd_wren = 1; v.ex_rd = 5; v.use_rs1 = 1; v.id_rs1 = 5;
                                                                  tbl[1]  = '{v, mk(F_LU, 0, 0, 0), "lu_rs1"};
    v.ex_rd = 0; v.id_rs1 = 0;                                    tbl[2]  = '{v, mk(F_NONE, 0, 0, 0), "lu_rd0"};
    v = base; v.is_load = 1; v.rd_wren = 1; v.ex_rd = 7; v.use_rs2 = 1; v.id_rs2 = 7;
                                                                  tbl[3]  = '{v, mk(F_LU, 0, 0, 0), "lu_rs2"};
    v = base; v.is_load = 1; v.rd_wren = 1; v.ex_rd = 5; v.id_rs1 = 5;
                                                                  tbl[4]  = '{v, mk(F_NONE, 0, 0, 0), "lu_nouse"};
    v.use_rs1 = 1; v.is_load = 0;                                 tbl[5]  = '{v, mk(F_NONE, 0, 0, 0), "lu_notload"};
    v.is_load = 1; v.rd_wren = 0;                                 tbl[6]  = '{v, mk(F_NONE, 0, 0, 0), "lu_nowren"};
    v = base; v.misp = 1; v.br_target = 32'h200; v.insn_vld = 1;  tbl[7]  = '{v, mk(F_MP, 32'h200, 0, 0), "misp"};
    v.is_load = 1; v.rd_wren = 1; v.ex_rd = 5; v.use_rs1 = 1; v.id_rs1 = 5;
                                                                  tbl[8]  = '{v, mk(F_MP, 32'h200, 0, 0), "misp_lu"};
    v.lsu_busy = 1;                                               tbl[9]  = '{v, mk(F_BUSY, 0, 0, 0), "busy_all"};
    v = base; v.insn_vld = 1; v.is_mret = 1; v.mepc = 32'h44;     tbl[10] = '{v, mk(F_MP, 32'h44, 0, 0), "mret"};
    v.insn_vld = 0;                                               tbl[11] = '{v, mk(F_NONE, 0, 0, 0), "mret_novld"};
    v.insn_vld = 1; v.misp = 1; v.br_target = 32'h200;            tbl[12] = '{v, mk(F_MP, 32'h44, 0, 0), "mret_misp"};

    // Reset with quiet inputs
    apply(base);
    i_rst_n = 1'b0;
    tick(); tick();
    chk("in_reset", mk(F_NONE, 0, 0, 0));
    i_rst_n = 1'b1;
    #1;
    chk("post_reset", mk(F_NONE, 0, 0, 0));

    for (int n = 0; n < 13; n++) begin
      apply(tbl[n].i);
      chk(tbl[n].name, tbl[n].o);
      tick();
    end
    idle(base, 4);

    // Interrupt entry, then refill masking with irq held, then irq dropped
    v = base; v.irq_req = 1; v.insn_vld = 1; v.ex_pc = 32'h40;
    apply(v); chk("irq_run", mk(F_NONE, 0, 0, 0)); tick();
    chk("irq_capture", mk(F_CAP, 0, 0, 1)); tick();
    chk("irq_trap", mk(F_TRAP, 32'h100, 32'h40, 2)); tick();
    for (int k = 0; k < 4; k++) begin
      chk("irq_masked", mk(F_NONE, 0, 0, 0)); tick();
    end
    chk("irq_repend", mk(F_CAP, 0, 0, 1));
    v.irq_req = 0; apply(v);
    chk("irq_drop", mk(F_NONE, 0, 0, 1)); tick();
    chk("irq_drop_run", mk(F_NONE, 0, 0, 0));

    // Capture blocked by LSU busy for 4 cycles
    v = base; v.irq_req = 1; v.insn_vld = 1; v.ex_pc = 32'h60;
    apply(v); chk("busy_run", mk(F_NONE, 0, 0, 0)); tick();
    v.lsu_busy = 1; apply(v);
    for (int k = 0; k < 4; k++) begin
      chk("busy_pend", mk(F_BUSY, 0, 0, 1)); tick();
    end
    v.lsu_busy = 0; apply(v);
    chk("busy_capture", mk(F_CAP, 0, 0, 1)); tick();
    chk("busy_trap", mk(F_TRAP, 32'h100, 32'h60, 2)); tick();
    idle(base, 4);

    // Mispredict coincident with IRQ_PEND
    v = base; v.irq_req = 1; v.insn_vld = 1; v.ex_pc = 32'h70;
    apply(v); chk("mp_run", mk(F_NONE, 0, 0, 0)); tick();
    v.misp = 1; v.br_target = 32'h80; apply(v);
    chk("mp_pend_redir", mk(F_MP, 32'h80, 0, 1)); tick();
    v.misp = 0; v.insn_vld = 0; apply(v);
    chk("mp_pend_bubble", mk(F_NONE, 0, 0, 1)); tick();
    v.insn_vld = 1; v.ex_pc = 32'h80; apply(v);
    chk("mp_capture", mk(F_CAP, 0, 0, 1)); tick();
    chk("mp_trap", mk(F_TRAP, 32'h100, 32'h80, 2)); tick();
    idle(base, 4);

    // Reset during TRAP aborts it and clears the refill counter
    v = base; v.irq_req = 1; v.insn_vld = 1; v.ex_pc = 32'h90;
    apply(v); tick(); tick();
    chk("rst_trap", mk(F_TRAP, 32'h100, 32'h90, 2));
    i_rst_n = 1'b0; #1;
    tick();
    chk("rst_held", mk(F_NONE, 0, 0, 0));
    i_rst_n = 1'b1; #1;
    chk("rst_released", mk(F_NONE, 0, 0, 0)); tick();
    chk("rst_nomask", mk(F_CAP, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule
